// File: rtl/ikascc_vrc_sync.sv
// rtl/ikascc_vrc_sync.sv - clock-synchronous SCC/SCC-I bank mapper
// Strobes are double-flopped into i_EMUCLK; bank/mode writes commit through a small write FSM.
module ikascc_vrc_sync #(
  parameter int BANK_W    = 6,
  parameter int MODE_SCCI = 0
) (
  input  logic              i_EMUCLK,
  input  logic              i_RST,
  input  logic              i_CS_n,
  input  logic              i_WR_n,
  input  logic              i_RD_n,
  input  logic [4:0]        i_ABHI,
  input  logic [2:0]        i_ABMID,
  input  logic [7:0]        i_ABLO,
  input  logic [7:0]        i_DB,
  output logic              o_ROMCS_n,
  output logic [BANK_W-1:0] o_ROMADDR,
  output logic              o_SCCREG_EN,
  output logic              o_SCCIREG_EN,
  output logic              o_WRPULSE,
  output logic [7:0]        o_MODE
);

  generate
    if (!((BANK_W == 6 && MODE_SCCI == 0) || (BANK_W == 8 && (MODE_SCCI == 0 || MODE_SCCI == 1)))) begin : g_bad_param
      $error("ikascc_vrc_sync: illegal BANK_W/MODE_SCCI combination");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ARMED, COMMIT} state_e;

  state_e            state_q;
  logic [1:0]        cs_sync_q, wr_sync_q, rd_sync_q;
  logic [4:0]        cap_abhi_q;
  logic [2:0]        cap_abmid_q;
  logic [7:0]        cap_ablo_q;
  logic [7:0]        cap_db_q;
  logic [BANK_W-1:0] bank_q [4];
  logic [7:0]        mode_q;
  logic              wrpulse_q;

  logic       scc_ok, scci_ok;
  logic       live_mode_addr, cap_mode_addr;
  logic       cap_hit, cap_bank_hit, mode_wr, bank_wr;
  logic [2:0] cap_bank_off;
  logic       unused_ok;

  assign scc_ok  = (bank_q[2][5:0] == 6'h3F) && !mode_q[5];
  assign scci_ok = (MODE_SCCI != 0) && bank_q[3][BANK_W-1] && mode_q[5];

  assign live_mode_addr = (i_ABHI == 5'b10111) && (i_ABMID == 3'b111) && (i_ABLO[7:1] == 7'h7F);
  assign cap_mode_addr  = (cap_abhi_q == 5'b10111) && (cap_abmid_q == 3'b111) && (cap_ablo_q[7:1] == 7'h7F);

  assign o_ROMCS_n    = i_CS_n | i_RD_n;
  assign o_ROMADDR    = bank_q[{~i_ABHI[3], i_ABHI[2]}];
  assign o_SCCREG_EN  = scc_ok && (i_ABHI == 5'b10011);
  assign o_SCCIREG_EN = scci_ok && (i_ABHI == 5'b10111) && !live_mode_addr;
  assign o_WRPULSE    = wrpulse_q;
  assign o_MODE       = mode_q;

  assign cap_hit = (scc_ok && (cap_abhi_q == 5'b10011)) ||
                   (scci_ok && (cap_abhi_q == 5'b10111) && !cap_mode_addr);

  assign cap_bank_off = cap_abhi_q[4:2] - 3'd2;
  assign cap_bank_hit = (cap_abhi_q[1:0] == 2'b10) && (cap_abhi_q[4:2] inside {3'b010, 3'b011, 3'b100, 3'b101});
  assign mode_wr      = (MODE_SCCI != 0) && cap_mode_addr;
  assign bank_wr      = cap_bank_hit && !mode_wr && !((MODE_SCCI != 0) && mode_q[4]);

  assign unused_ok = &{1'b0, rd_sync_q[1], cap_ablo_q[0]};

  // The update lands on the edge that leaves ARMED, i.e. the 3rd edge after WR_n rises;
  // COMMIT is the single cycle that carries the write pulse.
  always_ff @(posedge i_EMUCLK) begin
    if (i_RST) begin
      cs_sync_q   <= 2'b11;
      wr_sync_q   <= 2'b11;
      rd_sync_q   <= 2'b11;
      state_q     <= IDLE;
      cap_abhi_q  <= '0;
      cap_abmid_q <= '0;
      cap_ablo_q  <= '0;
      cap_db_q    <= '0;
      for (int i = 0; i < 4; i++) bank_q[i] <= BANK_W'(i);
      mode_q      <= 8'h00;
      wrpulse_q   <= 1'b0;
    end else begin
      cs_sync_q <= {cs_sync_q[0], i_CS_n};
      wr_sync_q <= {wr_sync_q[0], i_WR_n};
      rd_sync_q <= {rd_sync_q[0], i_RD_n};
      wrpulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!wr_sync_q[1] && !cs_sync_q[1]) begin
            state_q     <= ARMED;
            cap_abhi_q  <= i_ABHI;
            cap_abmid_q <= i_ABMID;
            cap_ablo_q  <= i_ABLO;
            cap_db_q    <= i_DB;
          end
        end
        ARMED: begin
          if (wr_sync_q[1]) begin
            state_q   <= COMMIT;
            wrpulse_q <= cap_hit;
            if (mode_wr) mode_q <= cap_db_q;
            if (bank_wr) bank_q[cap_bank_off[1:0]] <= cap_db_q[BANK_W-1:0];
          end else begin
            cap_abhi_q  <= i_ABHI;
            cap_abmid_q <= i_ABMID;
            cap_ablo_q  <= i_ABLO;
            cap_db_q    <= i_DB;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ikascc_vrc_sync.sv
// tb/tb_ikascc_vrc_sync.sv - self-checking bench for ikascc_vrc_sync (BANK_W=6 and SCC-I builds)
module tb_ikascc_vrc_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0, cs_n = 1'b1, wr_n = 1'b1, rd_n = 1'b1;
  logic [15:0] abus = 16'h0;
  logic [7:0]  db = 8'h0;

  logic       romcs6, scc6, scci6, pulse6;
  logic [5:0] romaddr6;
  logic [7:0] mode6;
  logic       romcs8, scc8, scci8, pulse8;
  logic [7:0] romaddr8, mode8_o;

  ikascc_vrc_sync #(.BANK_W(6), .MODE_SCCI(0)) u_d6 (
    .i_EMUCLK(clk), .i_RST(rst), .i_CS_n(cs_n), .i_WR_n(wr_n), .i_RD_n(rd_n),
    .i_ABHI(abus[15:11]), .i_ABMID(abus[10:8]), .i_ABLO(abus[7:0]), .i_DB(db),
    .o_ROMCS_n(romcs6), .o_ROMADDR(romaddr6), .o_SCCREG_EN(scc6), .o_SCCIREG_EN(scci6),
    .o_WRPULSE(pulse6), .o_MODE(mode6));

  ikascc_vrc_sync #(.BANK_W(8), .MODE_SCCI(1)) u_d8 (
    .i_EMUCLK(clk), .i_RST(rst), .i_CS_n(cs_n), .i_WR_n(wr_n), .i_RD_n(rd_n),
    .i_ABHI(abus[15:11]), .i_ABMID(abus[10:8]), .i_ABLO(abus[7:0]), .i_DB(db),
    .o_ROMCS_n(romcs8), .o_ROMADDR(romaddr8), .o_SCCREG_EN(scc8), .o_SCCIREG_EN(scci8),
    .o_WRPULSE(pulse8), .o_MODE(mode8_o));

  int n_chk = 0, n_err = 0;
  int m6[4], m8[4], mode8;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // 8 KB page -> bank window: page 2 maps to bank0, wrapping every four pages
  function automatic int win(input int a);
    return ((a >> 13) + 2) & 3;
  endfunction

  function automatic int bank_sel(input int a);
    for (int n = 0; n < 4; n++)
      if (a >= 'h5000 + n * 'h2000 && a < 'h5800 + n * 'h2000) return n;
    return -1;
  endfunction

  function automatic bit scc_exp(input int b2, input int md, input int a);
    return a >= 'h9800 && a <= 'h9FFF && (b2 & 'h3F) == 'h3F && (md & 'h20) == 0;
  endfunction

  function automatic bit scci_exp(input int b3, input int md, input int a);
    return a >= 'hB800 && a <= 'hBFFD && (b3 & 'h80) != 0 && (md & 'h20) != 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin m6[i] = i; m8[i] = i; end
    mode8 = 0;
  endtask

  task automatic model_write(input int a, input int d);
    int bs;
    bs = bank_sel(a);
    if (bs >= 0) m6[bs] = d & 'h3F;
    if (a == 'hBFFE || a == 'hBFFF) mode8 = d;
    else if (bs >= 0 && (mode8 & 'h10) == 0) m8[bs] = d;
  endtask

  task automatic sweep();
    int ra;
    int probe[8] = '{'h9800, 'h9A55, 'hB800, 'hBFFD, 'hBFFE, 'hBFFF, 'h9000, 'hB000};
    rd_n = 1'b0; cs_n = 1'b0;
    for (int p = 0; p < 8; p++) begin
      ra = p << 13;
      abus = 16'(ra);
      #1;
      check("romaddr6", romaddr6, m6[win(ra)]);
      check("romaddr8", romaddr8, m8[win(ra)]);
      check("romcs_rd", romcs8, 0);
    end
    foreach (probe[i]) begin
      abus = 16'(probe[i]);
      #1;
      check("sccreg6", scc6, scc_exp(m6[2], 0, probe[i]));
      check("sccreg8", scc8, scc_exp(m8[2], mode8, probe[i]));
      check("scci8", scci8, scci_exp(m8[3], mode8, probe[i]));
      check("scci6", scci6, 0);
    end
    check("mode8", mode8_o, mode8);
    check("mode6", mode6, 0);
    rd_n = 1'b1; cs_n = 1'b1;
    #1;
    check("romcs_idle", romcs6, 1);
  endtask

  task automatic wr(input int a, input int d, input bit cs, input int lowc);
    int p6, p8, ra;
    @(posedge clk); #1;
    abus = 16'(a); db = 8'(d); cs_n = cs; wr_n = 1'b0;
    repeat (lowc) @(posedge clk);
    #1 wr_n = 1'b1;
    p6 = (!cs && scc_exp(m6[2], 0, a)) ? 1 : 0;
    p8 = (!cs && (scc_exp(m8[2], mode8, a) || scci_exp(m8[3], mode8, a))) ? 1 : 0;
    @(posedge clk);
    @(posedge clk); #1;
    ra = a & 'hE000;
    abus = 16'(ra);
    #1;
    check("early6", romaddr6, m6[win(ra)]);
    check("early8", romaddr8, m8[win(ra)]);
    check("pulse_early", {pulse6, pulse8}, 0);
    @(posedge clk); #1;
    check("pulse6", pulse6, p6);
    check("pulse8", pulse8, p8);
    if (!cs) model_write(a, d);
    check("commit6", romaddr6, m6[win(ra)]);
    check("commit8", romaddr8, m8[win(ra)]);
    @(posedge clk); #1;
    check("pulse_end", {pulse6, pulse8}, 0);
    cs_n = 1'b1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    check("rst_pulse", {pulse6, pulse8}, 0);
  endtask

  initial begin
    int a, d, sel;
    model_reset();
    do_reset(2);
    sweep();

    wr('h7000, 'hC5, 1'b0, 4);
    abus = 16'h7000; #1;
    check("bank1_c5", romaddr6, 5);
    sweep();

    wr('h9000, 'h3F, 1'b0, 3);
    sweep();
    wr('h9800, 'hA5, 1'b0, 2);
    wr('h7000, 'h12, 1'b1, 3);
    sweep();

    wr('hB000, 'h80, 1'b0, 2);
    wr('hBFFE, 'h20, 1'b0, 2);
    sweep();
    wr('hB812, 'h01, 1'b0, 2);
    wr('hBFFE, 'h10, 1'b0, 2);
    wr('h5000, 'h07, 1'b0, 2);
    sweep();

    @(posedge clk); #1;
    abus = 16'h5000; db = 8'h55; cs_n = 1'b0; wr_n = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; wr_n = 1'b1; cs_n = 1'b1;
    model_reset();
    repeat (5) begin
      @(posedge clk); #1;
      check("midrst_pulse", {pulse6, pulse8}, 0);
    end
    sweep();

    wr('hB000, 'h11, 1'b0, 2);
    wr('hB000, 'h22, 1'b0, 2);
    check("b2b_bank3", m8[3], 'h22);
    sweep();

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2, 3: a = 'h5000 + sel * 'h2000 + $urandom_range(0, 'h7FF);
        4: a = 'h9800 + $urandom_range(0, 'h7FF);
        5: a = 'hB800 + $urandom_range(0, 'h7FF);
        6: a = 'hBFFE;
        7: a = 'hBFFF;
        default: a = $urandom_range(0, 'hFFFF);
      endcase
      d = $urandom_range(0, 255);
      wr(a, d, ($urandom_range(0, 9) == 0), $urandom_range(2, 4));
      if (i % 10 == 9) sweep();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
